// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed common-anode seven-segment scan controller
// Optional leading-zero blanking when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   display_column,
  output logic [7:0]              out
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);

  typedef enum logic {ST_DEAD, ST_ON} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           prescaler_q, prescaler_d;
  logic [IW-1:0]           index_q, index_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0]   col_q, col_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_done_q, frame_done_d;
  logic                    boundary;
  logic [3:0]              nib;
  logic                    dp_sel, blank_sel;
  logic [NUM_DIGITS-1:0]   lz_mask;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    boundary     = (prescaler_q == P_LAST) && (index_q == I_LAST);
    frame_done_d = boundary;
    prescaler_d  = (prescaler_q == P_LAST) ? '0 : prescaler_q + 1'b1;
    index_d      = index_q;
    if (prescaler_q == P_LAST) begin
      index_d = (index_q == I_LAST) ? '0 : index_q + 1'b1;
    end
    state_d = (prescaler_d < P_DEAD) ? ST_DEAD : ST_ON;

    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;
    // A load landing on the boundary bypasses the pending bank entirely.
    if (boundary && load) begin
      act_dig_d   = digits_in;
      act_dp_d    = dp_in;
      act_blank_d = blank_in;
      pend_flag_d = 1'b0;
    end else if (boundary && pend_flag_q) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_dig_d   = digits_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_flag_d  = 1'b1;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic zero_run;
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (act_dig_q[i*4 +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    nib       = 4'd0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    col_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == IW'(i)) begin
        nib       = act_dig_q[i*4 +: 4];
        dp_sel    = act_dp_q[i];
        blank_sel = act_blank_q[i] | lz_mask[i];
        col_d[i]  = (state_q == ST_ON) ? 1'b0 : 1'b1;
      end
    end
    if (state_q == ST_DEAD || blank_sel) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = {~dp_sel, hex7(nib)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_DEAD;
      prescaler_q  <= '0;
      index_q      <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_flag_q  <= 1'b0;
      col_q        <= '1;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescaler_q  <= prescaler_d;
      index_q      <= index_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      col_q        <= col_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign update_pending = pend_flag_q;
  assign frame_done     = frame_done_q;
  assign display_column = col_q;
  assign out            = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - scoreboard bench for seven_seg_scan_ctrl (4 digits, div 4, dead 1)
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        update_pending, frame_done;
  logic [3:0]  display_column;
  logic [7:0]  out;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] m_dig = '0, p_dig = '0;
  logic [3:0]  m_dp = '0, p_dp = '0, m_blank = '0, p_blank = '0;
  logic        m_pend = 1'b0;
  logic [11:0] exp_q[$];

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .update_pending(update_pending), .frame_done(frame_done),
    .display_column(display_column), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    logic blank;
    blank = m_blank[d];
`ifdef SEVEN_SEG_LZB_EN
    if (d > 0) begin
      logic z;
      z = 1'b1;
      for (int j = d; j < 4; j++) if (m_dig[j*4 +: 4] != 4'd0) z = 1'b0;
      blank = blank | z;
    end
`endif
    if (blank) return 8'hFF;
    return {~m_dp[d], hex7(m_dig[d*4 +: 4])};
  endfunction

  task automatic push_frame();
    for (int d = 0; d < 4; d++) exp_q.push_back({~(4'b0001 << d), exp_seg(d)});
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    chk("frame_done_timeout", frame_done, 1);
  endtask

  task automatic fd_frame();
    wait_fd();
    if (m_pend) begin
      m_dig = p_dig; m_dp = p_dp; m_blank = p_blank; m_pend = 1'b0;
    end
    chk("pending_cleared_at_frame", update_pending, 0);
    push_frame();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    p_dig = d; p_dp = dp; p_blank = bl; m_pend = 1'b1;
    chk("pending_after_load", update_pending, 1);
  endtask

  // Monitor: every slot start (column leaves all-off) pops one expected digit.
  logic [3:0] prev_col = 4'hF;
  int fd_gap = 0;
  bit have_fd = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_col = 4'hF;
      have_fd = 0;
      fd_gap = 0;
    end else begin
      fd_gap++;
      if (frame_done) begin
        if (have_fd) chk("frame_done_period", fd_gap, 16);
        have_fd = 1;
        fd_gap = 0;
      end
      if (display_column != 4'hF && prev_col == 4'hF && exp_q.size() > 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("slot_column", display_column, e[11:8]);
        chk("slot_segments", out, e[7:0]);
      end
      prev_col = display_column;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_column", display_column, 4'hF);
    chk("rst_out", out, 8'hFF);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pending", update_pending, 0);
    reset = 1'b1;
    push_frame();
    @(negedge clk);
    chk("first_cycle_dead", display_column, 4'hF);
    @(negedge clk);
    chk("second_cycle_digit0", display_column, 4'b1110);

    wait_fd();
    push_frame();
    do_load(16'h1234, 4'b0001, 4'b0000);
    fd_frame();
    do_load(16'h1111, 4'b0000, 4'b0000);
    @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000);
    fd_frame();
    do_load(16'h1234, 4'b0000, 4'b0100);
    fd_frame();

    repeat (15) @(negedge clk);
    digits_in = 16'hABCD; dp_in = 4'b0000; blank_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("boundary_frame_done", frame_done, 1);
    chk("boundary_no_pending", update_pending, 0);
    m_dig = 16'hABCD; m_dp = 4'b0000; m_blank = 4'b0000; m_pend = 1'b0;
    push_frame();
    @(negedge clk);
    chk("boundary_no_pending_later", update_pending, 0);

    do_load(16'h0050, 4'b0000, 4'b0000);
    fd_frame();

    do_load(16'h1234, 4'b0000, 4'b0000);
    repeat (14) @(negedge clk);
    chk("queue_drained_before_reset", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    chk("midrst_column", display_column, 4'hF);
    chk("midrst_out", out, 8'hFF);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_pending", update_pending, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_dig = '0; m_dp = '0; m_blank = '0; m_pend = 1'b0;
    push_frame();
    @(negedge clk);
    chk("post_rst_dead", display_column, 4'hF);
    @(negedge clk);
    chk("post_rst_digit0", display_column, 4'b1110);
    fd_frame();
    fd_frame();

    for (int n = 0; n < 40 && exp_q.size() > 0; n++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Parametrised multiplexed seven-segment display controller for the candy vending machine front panel. Drives up to 8 common-anode digits from a packed hex/BCD nibble bus with per-digit blanking and decimal points, a programmable refresh rate, and anti-ghosting dead time between digits. New display data takes effect only at scan-frame boundaries, so a frame never mixes old and new digits.

## Interface
- NUM_DIGITS, 8, number of scanned digits (1..8)
- REFRESH_DIV, 50000, clk cycles per digit slot (>= 2)
- DEAD_CYCLES, 500, cycles at slot start with all columns off (0 .. REFRESH_DIV-1)

- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- digits_in  input  4*NUM_DIGITS  nibble i = digit i (digit 0 = rightmost)
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_in  input  NUM_DIGITS  1 = digit dark
- load  input  1  one-cycle strobe; captures digits_in/dp_in/blank_in
- update_pending  output  1  captured data not yet applied
- frame_done  output  1  one-cycle pulse at frame end
- display_column  output  NUM_DIGITS  column enables, active-low, one-hot-low
- out  output  8  segments, active-low: out[7]=dp, out[6:0]=g,f,e,d,c,b,a

## Operation
- Registers: prescaler (0..REFRESH_DIV-1), digit index (0..NUM_DIGITS-1), active bank (digits/dp/blank), pending bank, pending flag.
- Prescaler increments every cycle; wraps at REFRESH_DIV-1 and advances index; index wraps NUM_DIGITS-1 -> 0.
- Per-slot FSM: DEAD while prescaler < DEAD_CYCLES (display_column all 1, out 8'hFF); ON otherwise (column[index]=0, others 1, out = decoded active nibble for index).
- Decode, hex 0-F, out[6:0]: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex). out[7] = ~dp.
- A blanked digit in ON state: column still enabled, out = 8'hFF (dp also dark).
- load: pending bank <= inputs, pending flag <= 1. A second load before application overwrites pending (last wins).
- Frame boundary = cycle where prescaler = REFRESH_DIV-1 and index = NUM_DIGITS-1: frame_done = 1 on the next cycle; if pending flag set, active bank <= pending bank and flag <= 0.
- load on the boundary cycle: inputs go directly to active bank; pending flag <= 0.
- update_pending = pending flag.

## Timing
- All outputs registered; column/segment outputs reflect prescaler/index state with 1-cycle latency.
- Reset (asserted any time, incl. mid-frame): prescaler 0, index 0, banks 0, flag 0; display_column all 1, out 8'hFF, frame_done 0, update_pending 0. After release, scan begins at digit 0, DEAD phase.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles; frame_done period equal.
- DEAD_CYCLES=0: no dead phase; columns switch directly.
- Prescaler width = $clog2(REFRESH_DIV); index width = max(1,$clog2(NUM_DIGITS)).

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking. Digit i > 0 is additionally blanked when it and all higher digits of the active bank are 0 (dp ignored for the test); digit 0 never auto-blanked. Evaluated on the active bank only.
- Undefined: only blank_in controls blanking; zeros displayed.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, reset low mid-scan -> display_column=4'hF, out=8'hFF immediately; after release digit 0 column low from cycle 2 of slot.
- load digits_in=16'h1234, dp_in=4'b0001 -> update_pending=1 until frame_done; next frame columns 0..3 show out=8'h19,8'h30,8'h24,8'h79 with digit 0 out[7]=0.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 displayed; 1111 never appears.
- load coincident with boundary cycle, 16'hABCD -> applied next frame, update_pending never asserts.
- blank_in=4'b0100 -> digit 2 slot: column enabled, out=8'hFF; frame_done pulses every 16 cycles.
- SEVEN_SEG_LZB_EN, digits 16'h0050 -> digits 3,2 out=8'hFF, digit 1 out=8'h12, digit 0 out=8'h40; without macro digits 3,2 show 8'h40.
